// File: rtl/al422_writer_rgb565_if.sv
// Pixel handshake and AL422 write-port signals for the RGB565 writer.
// master: pixel source side; slave: the writer block.
interface al422_writer_rgb565_if;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  fifo_data;
  logic        fifo_wck;
  logic        fifo_we_n;
  logic        fifo_wrst_n;

  modport master (
    output pix_data, pix_valid,
    input  pix_ready, fifo_data, fifo_wck, fifo_we_n, fifo_wrst_n
  );

  modport slave (
    input  pix_data, pix_valid,
    output pix_ready, fifo_data, fifo_wck, fifo_we_n, fifo_wrst_n
  );
endinterface

// File: rtl/al422_writer_rgb565.sv
// AL422 write-side front end: serialises RGB565 pixels into low/high bytes,
// generating WCK, /WE and a per-frame /WRST sequence.
module al422_writer_rgb565 #(
  parameter int unsigned PIXELS_PER_FRAME = 2048
) (
  input  logic                        in_clk,
  input  logic                        in_rst,
  input  logic                        frame_start,
  al422_writer_rgb565_if.slave        bus,
  output logic                        busy,
  output logic                        frame_done
);
  typedef enum logic [2:0] {
    IDLE, RST, WAIT_PIX, B0_SET, B0_CLK, B1_SET, B1_CLK, DONE
  } state_t;

  localparam logic [15:0] LAST = 16'(PIXELS_PER_FRAME);

  state_t      state, state_n;
  logic [1:0]  rst_cnt, rst_cnt_n;
  logic [15:0] pix_cnt, pix_cnt_n;
  logic [15:0] hold, hold_n;
  logic [7:0]  data_q, data_n;
  logic        wck_q, wck_n;
  logic        we_n_q, we_n_n;
  logic        wrst_n_q, wrst_n_n;
  logic        ready_q, ready_n;
  logic        busy_n, done_n;

  assign bus.fifo_data   = data_q;
  assign bus.fifo_wck    = wck_q;
  assign bus.fifo_we_n   = we_n_q;
  assign bus.fifo_wrst_n = wrst_n_q;
  assign bus.pix_ready   = ready_q;

  // Outputs are registered, so they are derived from the state being entered.
  always_comb begin
    state_n   = state;
    rst_cnt_n = rst_cnt;
    pix_cnt_n = pix_cnt;
    hold_n    = hold;
    unique case (state)
      IDLE: begin
        if (frame_start) begin
          pix_cnt_n = '0;
          rst_cnt_n = '0;
          state_n   = RST;
        end
      end
      RST: begin
        rst_cnt_n = rst_cnt + 2'd1;
        if (rst_cnt == 2'd3) state_n = WAIT_PIX;
      end
      WAIT_PIX: begin
        if (bus.pix_valid) begin
          hold_n  = bus.pix_data;
          state_n = B0_SET;
        end
      end
      B0_SET: state_n = B0_CLK;
      B0_CLK: state_n = B1_SET;
      B1_SET: begin
        // Count is bumped on entry to B1_CLK so B1_CLK already sees the new total.
        pix_cnt_n = pix_cnt + 16'd1;
        state_n   = B1_CLK;
      end
      B1_CLK: begin
        if (pix_cnt == LAST) begin
          state_n = DONE;
        end else if (bus.pix_valid) begin
          hold_n  = bus.pix_data;
          state_n = B0_SET;
        end else begin
          state_n = WAIT_PIX;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    wck_n    = (state_n == B0_CLK) || (state_n == B1_CLK) ||
               ((state_n == RST) && rst_cnt_n[0]);
    we_n_n   = !((state_n == B0_SET) || (state_n == B0_CLK) ||
                 (state_n == B1_SET) || (state_n == B1_CLK));
    wrst_n_n = (state_n != RST);
    ready_n  = (state_n == WAIT_PIX) || ((state_n == B1_CLK) && (pix_cnt_n != LAST));
    busy_n   = (state_n != IDLE);
    done_n   = (state_n == DONE);
    data_n   = data_q;
    if (state_n == B0_SET) data_n = hold_n[7:0];
    if (state_n == B1_SET) data_n = hold[15:8];
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state      <= IDLE;
      rst_cnt    <= '0;
      pix_cnt    <= '0;
      hold       <= '0;
      data_q     <= '0;
      wck_q      <= 1'b0;
      we_n_q     <= 1'b1;
      wrst_n_q   <= 1'b1;
      ready_q    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      rst_cnt    <= rst_cnt_n;
      pix_cnt    <= pix_cnt_n;
      hold       <= hold_n;
      data_q     <= data_n;
      wck_q      <= wck_n;
      we_n_q     <= we_n_n;
      wrst_n_q   <= wrst_n_n;
      ready_q    <= ready_n;
      busy       <= busy_n;
      frame_done <= done_n;
    end
  end
endmodule

// File: tb/tb_al422_writer_rgb565.sv
// Self-checking bench for al422_writer_rgb565 with a 3-pixel frame and a
// byte-stream/timing reference model derived from the pixel list.
module tb_al422_writer_rgb565;
  localparam int PPF = 3;

  logic in_clk = 1'b0;
  logic in_rst = 1'b1;
  logic frame_start = 1'b0;
  logic busy, frame_done;

  al422_writer_rgb565_if bus();

  al422_writer_rgb565 #(.PIXELS_PER_FRAME(PPF)) dut (
    .in_clk(in_clk), .in_rst(in_rst), .frame_start(frame_start),
    .bus(bus), .busy(busy), .frame_done(frame_done)
  );

  always #5 in_clk = ~in_clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic prev_wck = 1'b0;
  logic [7:0]  cap_q[$];
  int          cap_cyc[$];
  logic [15:0] acc_q[$];

  always @(posedge in_clk) begin
    cyc <= cyc + 1;
    if (!in_rst && bus.pix_valid && bus.pix_ready) acc_q.push_back(bus.pix_data);
  end

  // Bytes written to the FIFO are those present on a WCK rise with /WE low.
  always @(negedge in_clk) begin
    if (bus.fifo_wck && !prev_wck && !bus.fifo_we_n) begin
      cap_q.push_back(bus.fifo_data);
      cap_cyc.push_back(cyc);
    end
    prev_wck <= bus.fifo_wck;
    if (frame_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  function automatic logic [7:0] exp_byte(input logic [15:0] p[$], input int k);
    logic [15:0] w;
    w = p[k / 2];
    return (k % 2 == 0) ? w[7:0] : w[15:8];
  endfunction

  // Cycle offset of byte k's WCK rise from the first rise of the frame.
  function automatic int exp_off(input int k, input int gap, input int gidx);
    int i;
    i = k / 2;
    return 4 * i + 2 * (k % 2) + ((i >= gidx) ? gap : 0);
  endfunction

  task automatic drive_frame(input logic [15:0] pix[$], input int gap, input int gidx,
                             input int fs_rise, input int rst_rise,
                             output bit finished, output int we_hi, output int waits,
                             output int wrst_lo);
    int idx, refuse, rises;
    logic pw;
    idx = 0; refuse = 0; rises = 0; pw = 1'b0;
    finished = 0; we_hi = 0; waits = 0; wrst_lo = 0;
    for (int b = 0; b < 200; b++) begin
      @(negedge in_clk);
      frame_start = 1'b0;
      if (bus.fifo_wck && !pw && !bus.fifo_we_n) rises++;
      pw = bus.fifo_wck;
      if (frame_done) begin
        bus.pix_valid = 1'b0;
        finished = 1;
        return;
      end
      if (rises == rst_rise && !bus.fifo_wck && !bus.fifo_we_n) begin
        in_rst = 1'b1;
        bus.pix_valid = 1'b0;
        finished = 1;
        return;
      end
      if (rises > 0) begin
        if (bus.fifo_we_n) we_hi++;
        if (bus.pix_ready && bus.fifo_we_n && !bus.fifo_wck) waits++;
        if (!bus.fifo_wrst_n) wrst_lo++;
      end
      if (rises == fs_rise && bus.fifo_wck && !bus.fifo_we_n) frame_start = 1'b1;
      if (idx < pix.size() && idx == gidx && refuse < gap) begin
        bus.pix_valid = 1'b0;
        bus.pix_data  = 16'($urandom);
        if (bus.pix_ready) refuse++;
      end else begin
        bus.pix_valid = 1'b1;
        bus.pix_data  = (idx < pix.size()) ? pix[idx] : 16'($urandom);
        if (bus.pix_ready && idx < pix.size()) idx++;
      end
    end
  endtask

  task automatic test_reset();
    logic [13:0] obs;
    in_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      frame_start   = (i == 0) ? 1'b1 : 1'($urandom);
      bus.pix_valid = 1'b1;
      bus.pix_data  = 16'($urandom);
      @(negedge in_clk);
      obs = {bus.fifo_data, bus.fifo_wck, bus.fifo_we_n, bus.fifo_wrst_n, bus.pix_ready, busy, frame_done};
      tests++;
      if (obs !== 14'b0000_0000_0_1_1_0_0_0) begin
        fails++;
        $display("FAIL reset_hold[%0d]: outputs %b, required %b", i, obs, 14'b0000_0000_0_1_1_0_0_0);
      end
    end
    in_rst = 1'b0; frame_start = 1'b0; bus.pix_valid = 1'b0;
    @(negedge in_clk);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_release_busy: got %b, required 0", busy); end
  endtask

  task automatic test_frame_setup();
    logic [15:0] pix[$];
    logic [4:0] obs, exp5;
    logic pw;
    bit fin;
    int we_hi, waits, wrst_lo, lows, rises, c0, a0, d0, n;
    pw = 1'b0; lows = 0; rises = 0;
    for (int i = 0; i < PPF; i++) pix.push_back(16'($urandom));
    c0 = cap_q.size(); a0 = acc_q.size(); d0 = done_cnt;
    @(negedge in_clk); frame_start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge in_clk); frame_start = 1'b0;
      if (!bus.fifo_wrst_n) lows++;
      if (bus.fifo_wck && !pw) rises++;
      pw = bus.fifo_wck;
      obs  = {bus.fifo_wrst_n, bus.fifo_wck, bus.fifo_we_n, bus.pix_ready, busy};
      exp5 = {1'(i == 4), 1'(i < 4 && (i % 2) == 1), 1'b1, 1'(i == 4), 1'b1};
      tests++;
      if (obs !== exp5) begin
        fails++;
        $display("FAIL setup_cycle[%0d]: {wrst_n,wck,we_n,ready,busy}=%b, required %b", i + 1, obs, exp5);
      end
    end
    tests++;
    if (lows != 4) begin fails++; $display("FAIL setup_wrst_low: %0d cycles, required 4", lows); end
    tests++;
    if (rises != 2) begin fails++; $display("FAIL setup_wck_rises: %0d, required 2", rises); end
    drive_frame(pix, 0, 0, -1, -1, fin, we_hi, waits, wrst_lo);
    @(negedge in_clk);
    tests++;
    if (!fin || busy !== 1'b0) begin fails++; $display("FAIL setup_frame_end: finished=%0d busy=%b, required 1/0", fin, busy); end
    n = cap_q.size() - c0;
    tests++;
    if (n != 2 * PPF || done_cnt - d0 != 1 || acc_q.size() - a0 != PPF) begin
      fails++;
      $display("FAIL setup_counts: bytes=%0d done=%0d acc=%0d, required %0d/1/%0d", n, done_cnt - d0, acc_q.size() - a0, 2 * PPF, PPF);
    end
    for (int k = 0; k < n && k < 2 * PPF; k++) begin
      tests++;
      if (cap_q[c0 + k] !== exp_byte(pix, k)) begin
        fails++; $display("FAIL setup_byte[%0d]: got %h, required %h", k, cap_q[c0 + k], exp_byte(pix, k));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] pix[$];
    bit fin;
    int we_hi, waits, wrst_lo, c0, a0, d0, n;
    pix = '{16'h1234, 16'hABCD, 16'hF800};
    c0 = cap_q.size(); a0 = acc_q.size(); d0 = done_cnt;
    @(negedge in_clk); frame_start = 1'b1;
    drive_frame(pix, 0, 0, -1, -1, fin, we_hi, waits, wrst_lo);
    @(negedge in_clk);
    n = cap_q.size() - c0;
    tests++;
    if (!fin || n != 6) begin fails++; $display("FAIL b2b_bytes: finished=%0d count=%0d, required 1/6", fin, n); end
    for (int k = 0; k < n && k < 6; k++) begin
      tests++;
      if (cap_q[c0 + k] !== exp_byte(pix, k) || cap_cyc[c0 + k] - cap_cyc[c0] != exp_off(k, 0, 0)) begin
        fails++;
        $display("FAIL b2b_byte[%0d]: got %h at +%0d, required %h at +%0d", k, cap_q[c0 + k],
                 cap_cyc[c0 + k] - cap_cyc[c0], exp_byte(pix, k), exp_off(k, 0, 0));
      end
    end
    tests++;
    if (we_hi != 0) begin fails++; $display("FAIL b2b_we_n: high for %0d cycles mid-frame, required 0", we_hi); end
    tests++;
    if (acc_q.size() - a0 != 3) begin fails++; $display("FAIL b2b_accepts: %0d, required 3", acc_q.size() - a0); end
    tests++;
    if (done_cnt - d0 != 1 || (n == 6 && done_cyc != cap_cyc[c0 + 5] + 1)) begin
      fails++;
      $display("FAIL b2b_frame_done: pulses=%0d at cycle %0d, required 1 pulse one cycle after last rise", done_cnt - d0, done_cyc);
    end
  endtask

  task automatic test_stalled_source();
    logic [15:0] pix[$];
    bit fin;
    int we_hi, waits, wrst_lo, c0, d0, n;
    for (int i = 0; i < PPF; i++) pix.push_back(16'($urandom));
    c0 = cap_q.size(); d0 = done_cnt;
    @(negedge in_clk); frame_start = 1'b1;
    drive_frame(pix, 3, 1, -1, -1, fin, we_hi, waits, wrst_lo);
    @(negedge in_clk);
    tests++;
    if (waits != 3 || we_hi != 3) begin
      fails++; $display("FAIL stall_wait_cycles: wait=%0d we_n_high=%0d, required 3/3", waits, we_hi);
    end
    n = cap_q.size() - c0;
    tests++;
    if (!fin || n != 2 * PPF || done_cnt - d0 != 1) begin
      fails++; $display("FAIL stall_counts: finished=%0d bytes=%0d done=%0d, required 1/%0d/1", fin, n, done_cnt - d0, 2 * PPF);
    end
    for (int k = 0; k < n && k < 2 * PPF; k++) begin
      tests++;
      if (cap_q[c0 + k] !== exp_byte(pix, k) || cap_cyc[c0 + k] - cap_cyc[c0] != exp_off(k, 3, 1)) begin
        fails++;
        $display("FAIL stall_byte[%0d]: got %h at +%0d, required %h at +%0d", k, cap_q[c0 + k],
                 cap_cyc[c0 + k] - cap_cyc[c0], exp_byte(pix, k), exp_off(k, 3, 1));
      end
    end
  endtask

  task automatic test_frame_start_mid();
    logic [15:0] pix[$];
    bit fin;
    int we_hi, waits, wrst_lo, c0, a0, d0, n;
    for (int i = 0; i < PPF; i++) pix.push_back(16'($urandom));
    c0 = cap_q.size(); a0 = acc_q.size(); d0 = done_cnt;
    @(negedge in_clk); frame_start = 1'b1;
    drive_frame(pix, 0, 0, 3, -1, fin, we_hi, waits, wrst_lo);
    @(negedge in_clk);
    n = cap_q.size() - c0;
    tests++;
    if (wrst_lo != 0) begin fails++; $display("FAIL fsmid_no_rst: wrst_n low %0d cycles, required 0", wrst_lo); end
    tests++;
    if (!fin || n != 2 * PPF || done_cnt - d0 != 1 || acc_q.size() - a0 != PPF) begin
      fails++;
      $display("FAIL fsmid_counts: finished=%0d bytes=%0d done=%0d acc=%0d, required 1/%0d/1/%0d",
               fin, n, done_cnt - d0, acc_q.size() - a0, 2 * PPF, PPF);
    end
    for (int k = 0; k < n && k < 2 * PPF; k++) begin
      tests++;
      if (cap_q[c0 + k] !== exp_byte(pix, k)) begin
        fails++; $display("FAIL fsmid_byte[%0d]: got %h, required %h", k, cap_q[c0 + k], exp_byte(pix, k));
      end
    end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL fsmid_idle: busy=%b, required 0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] pix[$];
    logic [13:0] obs;
    bit fin;
    int we_hi, waits, wrst_lo, c0, a0, d0, n;
    for (int i = 0; i < PPF; i++) pix.push_back(16'($urandom));
    c0 = cap_q.size(); a0 = acc_q.size(); d0 = done_cnt;
    @(negedge in_clk); frame_start = 1'b1;
    drive_frame(pix, 0, 0, -1, 3, fin, we_hi, waits, wrst_lo);
    @(negedge in_clk); in_rst = 1'b0;
    obs = {bus.fifo_data, bus.fifo_wck, bus.fifo_we_n, bus.fifo_wrst_n, bus.pix_ready, busy, frame_done};
    tests++;
    if (!fin || obs !== 14'b0000_0000_0_1_1_0_0_0) begin
      fails++; $display("FAIL rstmid_outputs: reached=%0d outputs %b, required 1/%b", fin, obs, 14'b0000_0000_0_1_1_0_0_0);
    end
    repeat (3) @(negedge in_clk);
    n = cap_q.size() - c0;
    tests++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      fails++; $display("FAIL rstmid_no_done: pulses=%0d busy=%b, required 0/0", done_cnt - d0, busy);
    end
    tests++;
    if (n != 3 || acc_q.size() - a0 != 2) begin
      fails++; $display("FAIL rstmid_partial: bytes=%0d acc=%0d, required 3/2", n, acc_q.size() - a0);
    end
    for (int k = 0; k < n && k < 3; k++) begin
      tests++;
      if (cap_q[c0 + k] !== exp_byte(pix, k)) begin
        fails++; $display("FAIL rstmid_byte[%0d]: got %h, required %h", k, cap_q[c0 + k], exp_byte(pix, k));
      end
    end
    test_frame_setup();
  endtask

  task automatic test_random_frames();
    logic [15:0] pix[$];
    bit fin;
    int we_hi, waits, wrst_lo, c0, d0, n, gap, gidx;
    for (int f = 0; f < 4; f++) begin
      pix.delete();
      for (int i = 0; i < PPF; i++) pix.push_back(16'($urandom));
      gap  = int'($urandom_range(0, 3));
      gidx = int'($urandom_range(1, PPF - 1));
      c0 = cap_q.size(); d0 = done_cnt;
      repeat (int'($urandom_range(0, 2))) @(negedge in_clk);
      @(negedge in_clk); frame_start = 1'b1;
      drive_frame(pix, gap, gidx, -1, -1, fin, we_hi, waits, wrst_lo);
      @(negedge in_clk);
      n = cap_q.size() - c0;
      tests++;
      if (!fin || n != 2 * PPF || done_cnt - d0 != 1 || waits != gap) begin
        fails++;
        $display("FAIL rand_frame[%0d]: finished=%0d bytes=%0d done=%0d waits=%0d, required 1/%0d/1/%0d",
                 f, fin, n, done_cnt - d0, waits, 2 * PPF, gap);
      end
      for (int k = 0; k < n && k < 2 * PPF; k++) begin
        tests++;
        if (cap_q[c0 + k] !== exp_byte(pix, k) || cap_cyc[c0 + k] - cap_cyc[c0] != exp_off(k, gap, gidx)) begin
          fails++;
          $display("FAIL rand_byte[%0d.%0d]: got %h at +%0d, required %h at +%0d", f, k, cap_q[c0 + k],
                   cap_cyc[c0 + k] - cap_cyc[c0], exp_byte(pix, k), exp_off(k, gap, gidx));
        end
      end
      tests++;
      if (n == 2 * PPF && done_cyc != cap_cyc[c0 + n - 1] + 1) begin
        fails++; $display("FAIL rand_done_time[%0d]: at %0d, required %0d", f, done_cyc, cap_cyc[c0 + n - 1] + 1);
      end
    end
  endtask

  initial begin
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    test_reset();
    test_frame_setup();
    test_back_to_back();
    test_stalled_source();
    test_frame_start_mid();
    test_reset_mid();
    test_random_frames();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
